// File: rtl/ita_fifo_reader.sv
// Drains ITA output FIFO words into a buffer and serializes them MSB-slice first onto a narrow valid/ready stream.
// Optional ITA_FIFO_READER_BACK2BACK_EN: refill the buffer on the last-beat handshake to remove the per-word bubble.
module ita_fifo_reader #(
  parameter int unsigned WI         = 8,
  parameter int unsigned N          = 16,
  parameter int unsigned OUT_ELEMS  = 4,
  parameter int unsigned TILE_WORDS = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      fifo_empty_i,
  input  logic [N*WI-1:0]           data_from_fifo_i,
  output logic                      pop_from_fifo_o,
  output logic                      oup_valid_o,
  input  logic                      oup_ready_i,
  output logic [OUT_ELEMS*WI-1:0]   oup_data_o,
  output logic                      oup_last_o,
  output logic                      busy_o
);

  localparam int unsigned WORD_BITS = N * WI;
  localparam int unsigned BEAT_BITS = OUT_ELEMS * WI;
  localparam int unsigned BEATS     = N / OUT_ELEMS;
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WORD_W    = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) : 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                 state_q;
  logic [WORD_BITS-1:0]   buf_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [WORD_W-1:0]      word_q;

  logic is_full_c;
  logic last_beat_c;
  logic last_word_c;
  logic hs_c;
  logic word_done_c;

  assign is_full_c   = (state_q == ST_FULL);
  assign last_beat_c = (beat_q == BEAT_W'(BEATS - 1));
  assign last_word_c = (word_q == WORD_W'(TILE_WORDS - 1));
  assign hs_c        = is_full_c && oup_ready_i;
  assign word_done_c = hs_c && last_beat_c;

  // Pop is suppressed during reset so a discarded word never costs a FIFO entry.
`ifdef ITA_FIFO_READER_BACK2BACK_EN
  assign pop_from_fifo_o = !rst_i && !fifo_empty_i && (!is_full_c || word_done_c);
`else
  assign pop_from_fifo_o = !rst_i && !fifo_empty_i && !is_full_c;
`endif

  // Beat 0 is the most significant slice of the buffered word.
  assign oup_data_o  = BEAT_BITS'(buf_q >> (BEAT_BITS * (32'(BEATS - 1) - 32'(beat_q))));
  assign oup_valid_o = is_full_c;
  assign busy_o      = is_full_c;
  assign oup_last_o  = is_full_c && last_beat_c && last_word_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      buf_q   <= '0;
      beat_q  <= '0;
      word_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (pop_from_fifo_o) begin
            buf_q   <= data_from_fifo_i;
            beat_q  <= '0;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (hs_c) begin
            if (!last_beat_c) begin
              beat_q <= beat_q + BEAT_W'(1);
            end else begin
              word_q <= last_word_c ? '0 : word_q + WORD_W'(1);
              // A pop here can only happen with back-to-back refill enabled.
              if (pop_from_fifo_o) begin
                buf_q  <= data_from_fifo_i;
                beat_q <= '0;
              end else begin
                state_q <= ST_EMPTY;
              end
            end
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_ita_fifo_reader.sv
// Scoreboard bench for ita_fifo_reader: a queue-based FIFO model feeds the DUT and a negedge monitor checks every beat.
module tb_ita_fifo_reader;

  localparam int unsigned WI         = 8;
  localparam int unsigned N          = 16;
  localparam int unsigned OUT_ELEMS  = 4;
  localparam int unsigned TILE_WORDS = 2;
  localparam int unsigned BEATS      = N / OUT_ELEMS;
  localparam int unsigned WW         = N * WI;
  localparam int unsigned BW         = OUT_ELEMS * WI;
`ifdef ITA_FIFO_READER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clk;
  logic          rst_i;
  logic          fifo_empty_i;
  logic [WW-1:0] data_from_fifo_i;
  logic          pop_from_fifo_o;
  logic          oup_valid_o;
  logic          oup_ready_i;
  logic [BW-1:0] oup_data_o;
  logic          oup_last_o;
  logic          busy_o;

  ita_fifo_reader #(
    .WI(WI), .N(N), .OUT_ELEMS(OUT_ELEMS), .TILE_WORDS(TILE_WORDS)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .fifo_empty_i    (fifo_empty_i),
    .data_from_fifo_i(data_from_fifo_i),
    .pop_from_fifo_o (pop_from_fifo_o),
    .oup_valid_o     (oup_valid_o),
    .oup_ready_i     (oup_ready_i),
    .oup_data_o      (oup_data_o),
    .oup_last_o      (oup_last_o),
    .busy_o          (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
    logic          endw;
  } beat_t;

  beat_t         exp_q[$];
  logic [WW-1:0] fifo_q[$];
  int            hs_cyc[$];
  logic [WI-1:0] el [N];

  int n_cmp = 0, n_fail = 0, cyc = 0, hs_count = 0, pop_cnt = 0, model_word = 0;
  int ready_mode = 0, pat_idx = 0;
  bit gap_mode = 0, gap = 0;
  bit pop_s = 0, prev_rst = 1, prev_pop = 0, prev_valid = 0, prev_stall = 0;
  logic [BW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  beat_t         mon_e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    fifo_empty_i     = (fifo_q.size() == 0) || gap;
    data_from_fifo_i = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  // Packs el[] element 0 first and queues the beats it must produce.
  task automatic push_el();
    logic [WW-1:0] w;
    logic [BW-1:0] d;
    beat_t         b;
    w = '0;
    for (int i = 0; i < int'(N); i++) w = (w << WI) | WW'(el[i]);
    for (int bi = 0; bi < int'(BEATS); bi++) begin
      d = '0;
      for (int k = 0; k < int'(OUT_ELEMS); k++) d = (d << WI) | BW'(el[bi*int'(OUT_ELEMS)+k]);
      b.data = d;
      b.endw = (bi == int'(BEATS) - 1);
      b.last = b.endw && ((model_word % int'(TILE_WORDS)) == int'(TILE_WORDS) - 1);
      exp_q.push_back(b);
    end
    model_word++;
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic push_rand();
    for (int i = 0; i < int'(N); i++) el[i] = WI'($urandom);
    push_el();
  endtask

  task automatic push_seq(input int base);
    for (int i = 0; i < int'(N); i++) el[i] = WI'(base + i);
    push_el();
  endtask

  task automatic tick();
    @(posedge clk);
    if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
    cyc++;
    case (ready_mode)
      1:       oup_ready_i = ($urandom_range(0, 9) < 7);
      2:       oup_ready_i = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
      default: oup_ready_i = 1'b1;
    endcase
    pat_idx++;
    gap = gap_mode && ($urandom_range(0, 3) == 0);
    refresh();
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() > 0 || fifo_q.size() > 0) && g < 3000) begin
      tick();
      g++;
    end
    chk(name, 128'(g < 3000), 128'(1));
    tick();
    tick();
  endtask

  // Monitor: protocol rules plus scoreboard comparison on every handshake.
  always @(negedge clk) begin
    pop_s = pop_from_fifo_o;
    if (pop_from_fifo_o && !rst_i) begin
      pop_cnt++;
      chk("pop_not_empty", 128'(fifo_empty_i), 128'(0));
      if (oup_valid_o)
        chk("pop_while_full", 128'(1),
            128'(B2B && oup_ready_i && exp_q.size() > 0 && exp_q[0].endw));
    end
    if (!prev_rst) begin
      if (prev_pop) chk("valid_after_pop", 128'(oup_valid_o), 128'(1));
      else if (!prev_valid) chk("valid_without_pop", 128'(oup_valid_o), 128'(0));
      if (prev_stall) begin
        chk("stall_valid", 128'(oup_valid_o), 128'(1));
        chk("stall_data", 128'(oup_data_o), 128'(prev_data));
        chk("stall_last", 128'(oup_last_o), 128'(prev_last));
      end
    end
    if (oup_valid_o && oup_ready_i && !rst_i) begin
      hs_count++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 128'(1), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_data", 128'(oup_data_o), 128'(mon_e.data));
        chk("beat_last", 128'(oup_last_o), 128'(mon_e.last));
      end
    end
    prev_rst   = rst_i;
    prev_pop   = pop_from_fifo_o && !rst_i;
    prev_valid = oup_valid_o;
    prev_stall = oup_valid_o && !oup_ready_i;
    prev_data  = oup_data_o;
    prev_last  = oup_last_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, g, span;
    rst_i = 1'b1;
    oup_ready_i = 1'b0;
    fifo_empty_i = 1'b1;
    data_from_fifo_i = '0;
    tick();
    tick();
    chk("rst_valid", 128'(oup_valid_o), 128'(0));
    chk("rst_last", 128'(oup_last_o), 128'(0));
    chk("rst_data", 128'(oup_data_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_pop", 128'(pop_from_fifo_o), 128'(0));

    // Single word 0x00..0x0F, pushed while still in reset.
    model_word = 0;
    push_seq(0);
    #1;
    chk("pop_in_reset", 128'(pop_from_fifo_o), 128'(0));
    tick();
    pop_cnt = 0;
    hs_cyc.delete();
    rst_i = 1'b0;
    wait_drain("t1_drain");
    chk("t1_pops", 128'(pop_cnt), 128'(1));
    chk("t1_beats", 128'(hs_cyc.size()), 128'(BEATS));
    if (hs_cyc.size() == BEATS)
      chk("t1_consecutive", 128'(hs_cyc[BEATS-1] - hs_cyc[0] + 1), 128'(BEATS));

    // Back-pressure with ready pattern 1,0,0,1.
    ready_mode = 2;
    pat_idx = 0;
    pop_cnt = 0;
    push_seq(8'h10);
    push_seq(8'h40);
    wait_drain("t2_drain");
    chk("t2_pops", 128'(pop_cnt), 128'(2));

    // Tile-last over five words.
    ready_mode = 0;
    for (int i = 0; i < 5; i++) push_rand();
    wait_drain("t3_drain");

    // Streaming throughput, FIFO pre-filled and ready high.
    hs_cyc.delete();
    for (int i = 0; i < 8; i++) push_rand();
    wait_drain("t4_drain");
    chk("t4_beats", 128'(hs_cyc.size()), 128'(8 * BEATS));
    if (hs_cyc.size() == 8 * BEATS) begin
      span = hs_cyc[8*BEATS-1] - hs_cyc[0] + 1;
      chk("t4_span", 128'(span), 128'(8 * BEATS + (B2B ? 0 : 7)));
    end

    // Empty FIFO held.
    ready_mode = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 5 == 0) begin
        chk("empty_pop", 128'(pop_from_fifo_o), 128'(0));
        chk("empty_valid", 128'(oup_valid_o), 128'(0));
      end
    end

    // Randomized traffic with FIFO gaps and random back-pressure.
    gap_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) push_rand();
      tick();
    end
    wait_drain("rand_drain");
    gap_mode = 0;
    gap = 0;
    refresh();

    // Mid-word reset with the tile count off zero.
    ready_mode = 0;
    if (model_word % int'(TILE_WORDS) == 0) begin
      push_rand();
      wait_drain("t6_pre_drain");
    end
    push_rand();
    tgt = hs_count + 2;
    g = 0;
    while (hs_count < tgt && g < 200) begin
      tick();
      g++;
    end
    chk("t6_reach_beat1", 128'(hs_count >= tgt), 128'(1));
    rst_i = 1'b1;
    oup_ready_i = 1'b0;
    #1;
    chk("t6_pop_in_reset", 128'(pop_from_fifo_o), 128'(0));
    exp_q.delete();
    model_word = 0;
    tick();
    rst_i = 1'b0;
    #1;
    chk("t6_valid", 128'(oup_valid_o), 128'(0));
    chk("t6_last", 128'(oup_last_o), 128'(0));
    chk("t6_data", 128'(oup_data_o), 128'(0));
    chk("t6_busy", 128'(busy_o), 128'(0));
    push_rand();
    push_rand();
    push_rand();
    wait_drain("t6_post_drain");
    chk("end_fifo_left", 128'(fifo_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
